csi_rx_lane_delay_cal: RTL



---
 rtl/csi_rx_lane_delay_cal.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/csi_rx_lane_delay_cal.sv
// Per-lane IDELAY tap calibration: sweeps all 32 taps counting HS sync hits, then loads the
// centre of the longest passing window and checks the PHY read-back.
module csi_rx_lane_delay_cal #(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned WINDOW_CYC  = 256,
    parameter int unsigned HIT_MIN     = 4,
    parameter logic [7:0]  SYNC_BYTE   = 8'hB8,
    parameter logic [4:0]  DEFAULT_TAP = 5'd0
) (
    input  logic       byte_clock,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic [7:0] deser_in_i,
    input  logic [4:0] phy_delay_out_i,
    output logic [4:0] delay_in_o,
    output logic       load_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fail_o,
    output logic [4:0] final_tap_o,
    output logic [5:0] eye_width_o
);

    localparam int unsigned MaxCyc = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
    localparam int unsigned HitW   = $clog2(WINDOW_CYC + 1);

    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
    localparam logic [CntW-1:0] WindowLast = CntW'(WINDOW_CYC - 1);
    localparam logic [CntW-1:0] VerifyLast = CntW'(1);
    localparam logic [HitW-1:0] HitSat     = HitW'(WINDOW_CYC);
    localparam logic [HitW-1:0] HitMin     = HitW'(HIT_MIN);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StObserve,
        StEval,
        StApply,
        StVerify,
        StDone
    } state_e;

    state_e          state_q;
    logic [4:0]      tap_q;
    logic [CntW-1:0] cnt_q;
    logic [HitW-1:0] hits_q;
    logic [7:0]      prev_q;
    logic [5:0]      cur_len_q;
    logic [4:0]      cur_start_q;
    logic [5:0]      best_len_q;
    logic [4:0]      best_start_q;
    logic [4:0]      target_q;
    logic [4:0]      delay_q;
    logic            load_q;
    logic            busy_q;
    logic            done_q;
    logic            fail_q;
    logic [4:0]      final_tap_q;
    logic [5:0]      eye_width_q;

    // Sync byte may straddle two consecutive deserialised bytes at any bit offset.
    logic [15:0] sync_win;
    logic        sync_hit;

    always_comb begin
        sync_win = {deser_in_i, prev_q};
        sync_hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (sync_win[k +: 8] == SYNC_BYTE) begin
                sync_hit = 1'b1;
            end
        end
    end

    // Window tracking as it will stand after the current EVAL cycle.
    logic       tap_pass;
    logic [5:0] cur_len_upd;
    logic [4:0] cur_start_upd;
    logic [5:0] best_len_upd;
    logic [4:0] best_start_upd;
    logic [5:0] centre;
    logic [4:0] target_calc;

    always_comb begin
        tap_pass       = (hits_q >= HitMin);
        cur_len_upd    = tap_pass ? (cur_len_q + 6'd1) : 6'd0;
        cur_start_upd  = (tap_pass && (cur_len_q == 6'd0)) ? tap_q : cur_start_q;
        best_len_upd   = best_len_q;
        best_start_upd = best_start_q;
        if (cur_len_upd > best_len_q) begin
            best_len_upd   = cur_len_upd;
            best_start_upd = cur_start_upd;
        end
        centre      = {1'b0, best_start_upd} + ((best_len_upd - 6'd1) >> 1);
        target_calc = (best_len_upd == 6'd0) ? DEFAULT_TAP : centre[4:0];
    end

    always_ff @(posedge byte_clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            tap_q        <= 5'd0;
            cnt_q        <= '0;
            hits_q       <= '0;
            prev_q       <= 8'd0;
            cur_len_q    <= 6'd0;
            cur_start_q  <= 5'd0;
            best_len_q   <= 6'd0;
            best_start_q <= 5'd0;
            target_q     <= 5'd0;
            delay_q      <= 5'd0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            final_tap_q  <= 5'd0;
            eye_width_q  <= 6'd0;
        end else begin
            prev_q <= deser_in_i;
            load_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q      <= StLoad;
                        tap_q        <= 5'd0;
                        cur_len_q    <= 6'd0;
                        cur_start_q  <= 5'd0;
                        best_len_q   <= 6'd0;
                        best_start_q <= 5'd0;
                        done_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        delay_q      <= 5'd0;
                        load_q       <= 1'b1;
                    end
                end
                StLoad: begin
                    state_q <= StSettle;
                    cnt_q   <= '0;
                end
                StSettle: begin
                    if (cnt_q == SettleLast) begin
                        state_q <= StObserve;
                        cnt_q   <= '0;
                        hits_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StObserve: begin
                    if (sync_hit && (hits_q != HitSat)) begin
                        hits_q <= hits_q + HitW'(1);
                    end
                    if (cnt_q == WindowLast) begin
                        state_q <= StEval;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StEval: begin
                    cur_len_q    <= cur_len_upd;
                    cur_start_q  <= cur_start_upd;
                    best_len_q   <= best_len_upd;
                    best_start_q <= best_start_upd;
                    load_q       <= 1'b1;
                    if (tap_q == 5'd31) begin
                        state_q  <= StApply;
                        target_q <= target_calc;
                        delay_q  <= target_calc;
                        if (best_len_upd == 6'd0) begin
                            fail_q <= 1'b1;
                        end
                    end else begin
                        state_q <= StLoad;
                        tap_q   <= tap_q + 5'd1;
                        delay_q <= tap_q + 5'd1;
                    end
                end
                StApply: begin
                    state_q <= StVerify;
                    cnt_q   <= '0;
                end
                StVerify: begin
                    if (cnt_q == VerifyLast) begin
                        if (phy_delay_out_i != target_q) begin
                            fail_q <= 1'b1;
                        end
                        final_tap_q <= target_q;
                        eye_width_q <= best_len_q;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign delay_in_o  = delay_q;
    assign load_o      = load_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign final_tap_o = final_tap_q;
    assign eye_width_o = eye_width_q;

endmodule
